// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one row at a time, debounces the
// whole-keypad result scan by scan, and shifts each accepted hex digit into
// a 16-bit entry register. One full scan is 16 display_clk cycles: four
// cycles per row, with the columns sampled on the last cycle of each row.
//
// Ports
//   display_clk  in   scan clock (1 ms tick)
//   reset        in   asynchronous, active-high reset
//   col_n[3:0]   in   keypad columns, active-low, asynchronous to the clock
//   clear        in   synchronous clear of value and digit_count
//   row_n[3:0]   out  row strobes, active-low, exactly one low at a time
//   value[15:0]  out  entered digits, newest digit in [3:0]
//   key_code[3:0] out code (4*row + col) of the last accepted key
//   key_valid    out  one-cycle pulse when a key is accepted
//   digit_count[2:0] out digits entered since reset/clear, saturates at 4
module hex_keypad_scanner #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        display_clk,
  input  logic        reset,
  input  logic [3:0]  col_n,
  input  logic        clear,
  output logic [3:0]  row_n,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [2:0]  digit_count
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_e;

  // ---------------------------------------------------------------------
  // Column synchronizer. Idle (all high) is the reset value so no phantom
  // key is seen straight out of reset.
  // ---------------------------------------------------------------------
  logic [3:0] col_s1_q, col_s2_q;

  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Scan counter and row strobes
  // ---------------------------------------------------------------------
  logic [3:0] scan_cnt_q, scan_cnt_d;

  assign scan_cnt_d = scan_cnt_q + 4'd1;

  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) scan_cnt_q <= 4'd0;
    else       scan_cnt_q <= scan_cnt_d;
  end

  assign row_n = ~(4'b0001 << scan_cnt_q[3:2]);

  // ---------------------------------------------------------------------
  // Column decode of the synchronized sample: number of low columns and
  // the index of the highest one (only meaningful when exactly one is low).
  // ---------------------------------------------------------------------
  logic [2:0] col_hits;
  logic [1:0] col_idx;

  always_comb begin
    col_hits = '0;
    col_idx  = '0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s2_q[c]) begin
        col_hits = col_hits + 3'd1;
        col_idx  = 2'(c);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-scan accumulator. hits saturates at 2 because anything beyond
  // "more than one key" is treated the same way.
  // ---------------------------------------------------------------------
  logic       sample, scan_end;
  logic [1:0] hits_q, hits_d, hits_acc;
  logic [3:0] cand_q, cand_d, cand_acc;
  logic [2:0] hits_sum;

  assign sample   = (scan_cnt_q[1:0] == 2'd3);
  assign scan_end = (scan_cnt_q == 4'hF);

  always_comb begin
    hits_sum = {1'b0, hits_q} + (sample ? col_hits : 3'd0);
    hits_acc = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    cand_acc = (sample && col_hits != 3'd0) ? {scan_cnt_q[3:2], col_idx} : cand_q;
    // The scan result is consumed on the edge ending slot 15, so the
    // accumulator starts clean for slot 0 of the next scan.
    hits_d   = scan_end ? 2'd0 : hits_acc;
    cand_d   = scan_end ? 4'd0 : cand_acc;
  end

  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      hits_q <= 2'd0;
      cand_q <= 4'd0;
    end else begin
      hits_q <= hits_d;
      cand_q <= cand_d;
    end
  end

  // Scan verdicts, valid only on the scan-ending cycle. MULTI folds into
  // res_quiet: it counts as empty for release and is never accepted.
  logic res_key, res_quiet;

  assign res_key   = scan_end && (hits_acc == 2'd1);
  assign res_quiet = scan_end && (hits_acc != 2'd1);

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] deb_cnt_q, deb_cnt_d;
  logic [3:0] deb_code_q, deb_code_d;
  logic       accept;
  logic [3:0] acc_code;

  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      deb_cnt_q  <= 4'd0;
      deb_code_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_code_q <= deb_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    deb_code_d = deb_code_q;
    accept     = 1'b0;
    acc_code   = deb_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (res_key) begin
          deb_code_d = cand_acc;
          if (DEB_N == 4'd1) begin
            // Single-scan debounce: the first sighting is already enough.
            accept    = 1'b1;
            acc_code  = cand_acc;
            deb_cnt_d = 4'd1;
            state_d   = S_PRESSED;
          end else begin
            deb_cnt_d = 4'd1;
            state_d   = S_DEBOUNCE;
          end
        end
      end

      S_DEBOUNCE: begin
        if (res_key) begin
          if (cand_acc == deb_code_q) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if (deb_cnt_q + 4'd1 == DEB_N) begin
              accept  = 1'b1;
              state_d = S_PRESSED;
            end
          end else begin
            // A different key restarts the count rather than dropping out.
            deb_code_d = cand_acc;
            deb_cnt_d  = 4'd1;
          end
        end else if (res_quiet) begin
          deb_cnt_d = 4'd0;
          state_d   = S_IDLE;
        end
      end

      S_PRESSED: begin
        if (res_quiet) begin
          if (DEB_N == 4'd1) begin
            // One empty scan already meets the release count.
            deb_cnt_d = 4'd0;
            state_d   = S_IDLE;
          end else begin
            deb_cnt_d = 4'd1;
            state_d   = S_RELEASE;
          end
        end
      end

      S_RELEASE: begin
        if (res_key) begin
          // Bounce during release: back to held, never a second accept.
          state_d = S_PRESSED;
        end else if (res_quiet) begin
          if (deb_cnt_q + 4'd1 == DEB_N) begin
            deb_cnt_d = 4'd0;
            state_d   = S_IDLE;
          end else begin
            deb_cnt_d = deb_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        deb_cnt_d = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Entry register. clear wins over the old contents but still keeps a
  // digit accepted on the same edge.
  // ---------------------------------------------------------------------
  logic [15:0] value_q, value_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q;

  always_comb begin
    value_d    = value_q;
    count_d    = count_q;
    key_code_d = key_code_q;
    if (accept) begin
      key_code_d = acc_code;
      value_d    = {value_q[11:0], acc_code};
      count_d    = (count_q >= 3'd4) ? 3'd4 : count_q + 3'd1;
    end
    if (clear) begin
      value_d = accept ? {12'h000, acc_code} : 16'h0000;
      count_d = accept ? 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      value_q     <= 16'h0000;
      count_q     <= 3'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      value_q     <= value_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= accept;
    end
  end

  assign value       = value_q;
  assign digit_count = count_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner. A keypad model turns a 16-bit
// "keys held" mask into column levels for whichever row is strobed. Stimulus
// changes only at scan boundaries, and a per-scan reference model decides
// from the sequence of whole-scan outcomes when a press must be accepted.
module tb_hex_keypad_scanner;
  localparam int DS = 4;

  logic        display_clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [2:0]  digit_count;
  logic [15:0] keys = 16'h0000;

  hex_keypad_scanner #(.DEBOUNCE_SCANS(DS)) dut (
    .display_clk (display_clk),
    .reset       (reset),
    .col_n       (col_n),
    .clear       (clear),
    .row_n       (row_n),
    .value       (value),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .digit_count (digit_count)
  );

  always #5 display_clk = ~display_clk;

  // Keypad: a held key on a strobed row pulls its column low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int scan_idx = 0;
  int stray = 0;
  bit obs_kv [0:1023];
  bit exp_kv [0:1023];

  // Reference model, in terms of scan history
  logic [15:0] m_value;
  logic [3:0]  m_code;
  int          m_count;
  int          m_run_len;   // consecutive single-key scans of the same key
  int          m_run_code;
  int          m_quiet;     // consecutive scans without exactly one key
  bit          m_armed;     // a new press may be accepted

  task automatic model_reset();
    m_value = 16'h0; m_code = 4'h0; m_count = 0;
    m_run_len = 0; m_run_code = 0; m_quiet = 0; m_armed = 1'b1;
  endtask

  task automatic model_scan(input logic [15:0] mask, input bit clr);
    int n, k;
    bit acc;
    n = $countones(mask);
    k = 0;
    acc = 1'b0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = i;
    if (n == 1) begin
      m_quiet = 0;
      if (m_run_len > 0 && k == m_run_code) m_run_len++;
      else begin m_run_code = k; m_run_len = 1; end
      if (m_armed && m_run_len == DS) begin acc = 1'b1; m_armed = 1'b0; end
    end else begin
      m_run_len = 0;
      m_quiet++;
      if (!m_armed && m_quiet >= DS) m_armed = 1'b1;
    end
    if (acc) begin
      m_code  = 4'(k);
      m_value = {m_value[11:0], 4'(k)};
      m_count = (m_count < 4) ? m_count + 1 : 4;
    end
    if (clr) begin
      m_value = acc ? {12'h000, 4'(k)} : 16'h0000;
      m_count = acc ? 1 : 0;
    end
    if (scan_idx < 1024) exp_kv[scan_idx] = acc;
  endtask

  // Drive one full scan starting at slot 0; ends at slot 0 of the next scan,
  // where any accept of this scan shows up on key_valid.
  task automatic run_scan(input logic [15:0] mask, input bit clr);
    keys = mask;
    for (int i = 1; i < 16; i++) begin
      @(negedge display_clk);
      if (key_valid) stray++;
    end
    clear = clr;
    @(negedge display_clk);
    clear = 1'b0;
    scan_idx++;
    if (scan_idx < 1024) obs_kv[scan_idx] = key_valid;
    model_scan(mask, clr);
  endtask

  function automatic int pulses_since(input int s0);
    int n = 0;
    for (int s = s0 + 1; s <= scan_idx && s < 1024; s++) n += int'(obs_kv[s]);
    return n;
  endfunction

  task automatic test_reset();
    logic [3:0] row_tbl [4];
    int s0;
    row_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset = 1'b1; clear = 1'b0; keys = 16'h0;
    repeat (3) @(negedge display_clk);
    checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL reset_row_n got %b exp 1110", row_n); end
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL reset_value got %h exp 0000", value); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code got %h exp 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b exp 0", key_valid); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_digit_count got %0d exp 0", digit_count); end
    reset = 1'b0;
    model_reset();
    s0 = scan_idx;
    for (int cyc = 0; cyc < 208; cyc++) begin
      checks++;
      if (row_n !== row_tbl[(cyc % 16) / 4]) begin
        errors++; $display("FAIL idle_row_n cycle %0d got %b exp %b", cyc, row_n, row_tbl[(cyc % 16) / 4]);
      end
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_key_valid cycle %0d got %b exp 0", cyc, key_valid); end
      @(negedge display_clk);
      if (cyc % 16 == 15) begin
        scan_idx++;
        obs_kv[scan_idx] = key_valid;
        model_scan(16'h0, 1'b0);
      end
    end
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL idle_value got %h exp 0000", value); end
    checks++; if (pulses_since(s0) !== 0) begin errors++; $display("FAIL idle_pulses got %0d exp 0", pulses_since(s0)); end
  endtask

  task automatic test_single_key();
    int s0 = scan_idx;
    stray = 0;
    repeat (10) run_scan(16'h1 << 9, 1'b0);
    checks++; if (pulses_since(s0) !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", pulses_since(s0)); end
    checks++; if (obs_kv[s0 + 4] !== 1'b1) begin errors++; $display("FAIL single_latency got %b exp 1 after 4th scan", obs_kv[s0 + 4]); end
    checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL single_code got %h exp 9", key_code); end
    checks++; if (value !== 16'h0009) begin errors++; $display("FAIL single_value got %h exp 0009", value); end
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", digit_count); end
    repeat (6) run_scan(16'h0, 1'b0);
    checks++; if (stray !== 0) begin errors++; $display("FAIL single_stray got %0d exp 0", stray); end
    for (int s = s0 + 1; s <= scan_idx; s++) begin
      checks++;
      if (obs_kv[s] !== exp_kv[s]) begin errors++; $display("FAIL single_pulse scan %0d got %b exp %b", s, obs_kv[s], exp_kv[s]); end
    end
  endtask

  task automatic test_sequence();
    int s0 = scan_idx;
    stray = 0;
    for (int k = 1; k <= 5; k++) begin
      repeat (6) run_scan(16'h1 << k, 1'b0);
      repeat (6) run_scan(16'h0, 1'b0);
    end
    checks++; if (pulses_since(s0) !== 5) begin errors++; $display("FAIL seq_pulses got %0d exp 5", pulses_since(s0)); end
    checks++; if (value !== 16'h2345) begin errors++; $display("FAIL seq_value got %h exp 2345", value); end
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL seq_count got %0d exp 4", digit_count); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL seq_code got %h exp 5", key_code); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL seq_stray got %0d exp 0", stray); end
    for (int s = s0 + 1; s <= scan_idx; s++) begin
      checks++;
      if (obs_kv[s] !== exp_kv[s]) begin errors++; $display("FAIL seq_pulse scan %0d got %b exp %b", s, obs_kv[s], exp_kv[s]); end
    end
  endtask

  task automatic test_bounce();
    int s0 = scan_idx;
    logic [15:0] v0 = value;
    stray = 0;
    repeat (10) begin
      run_scan(16'h1 << 7, 1'b0);
      run_scan(16'h0, 1'b0);
    end
    checks++; if (pulses_since(s0) !== 0) begin errors++; $display("FAIL bounce_pulses got %0d exp 0", pulses_since(s0)); end
    checks++; if (value !== v0) begin errors++; $display("FAIL bounce_value got %h exp %h", value, v0); end
    repeat (6) run_scan(16'h1 << 7, 1'b0);
    checks++; if (pulses_since(s0) !== 1) begin errors++; $display("FAIL bounce_hold_pulses got %0d exp 1", pulses_since(s0)); end
    checks++; if (key_code !== 4'h7) begin errors++; $display("FAIL bounce_code got %h exp 7", key_code); end
    repeat (6) run_scan(16'h0, 1'b0);
    checks++; if (stray !== 0) begin errors++; $display("FAIL bounce_stray got %0d exp 0", stray); end
  endtask

  task automatic test_multi();
    int s0 = scan_idx;
    logic [15:0] v0 = value;
    stray = 0;
    repeat (10) run_scan(16'h0021, 1'b0);
    checks++; if (pulses_since(s0) !== 0) begin errors++; $display("FAIL multi_pulses got %0d exp 0", pulses_since(s0)); end
    checks++; if (value !== v0) begin errors++; $display("FAIL multi_value got %h exp %h", value, v0); end
    repeat (6) run_scan(16'h0020, 1'b0);
    checks++; if (pulses_since(s0) !== 1) begin errors++; $display("FAIL multi_release_pulses got %0d exp 1", pulses_since(s0)); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL multi_code got %h exp 5", key_code); end
    repeat (6) run_scan(16'h0, 1'b0);
    checks++; if (value !== m_value) begin errors++; $display("FAIL multi_model_value got %h exp %h", value, m_value); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL multi_stray got %0d exp 0", stray); end
  endtask

  task automatic test_clear();
    stray = 0;
    for (int k = 1; k <= 4; k++) begin
      repeat (6) run_scan(16'h1 << k, 1'b0);
      repeat (6) run_scan(16'h0, 1'b0);
    end
    checks++; if (value !== 16'h1234) begin errors++; $display("FAIL clear_pre_value got %h exp 1234", value); end
    repeat (3) run_scan(16'h1 << 10, 1'b0);
    run_scan(16'h1 << 10, 1'b1);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL clear_key_valid got %b exp 1", key_valid); end
    checks++; if (value !== 16'h000A) begin errors++; $display("FAIL clear_value got %h exp 000a", value); end
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL clear_count got %0d exp 1", digit_count); end
    checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL clear_code got %h exp a", key_code); end
    repeat (2) run_scan(16'h1 << 10, 1'b0);
    run_scan(16'h0, 1'b1);
    checks++; if (value !== 16'h0000) begin errors++; $display("FAIL clear_plain_value got %h exp 0000", value); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL clear_plain_count got %0d exp 0", digit_count); end
    repeat (5) run_scan(16'h0, 1'b0);
    checks++; if (stray !== 0) begin errors++; $display("FAIL clear_stray got %0d exp 0", stray); end
  endtask

  task automatic test_reset_mid();
    int s0;
    stray = 0;
    repeat (2) run_scan(16'h1 << 3, 1'b0);
    repeat (5) @(negedge display_clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL midreset_row_n got %b exp 1110", row_n); end
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL midreset_value got %h exp 0000", value); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL midreset_code got %h exp 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", key_valid); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", digit_count); end
    @(negedge display_clk);
    reset = 1'b0;
    model_reset();
    s0 = scan_idx;
    repeat (3) run_scan(16'h1 << 3, 1'b0);
    checks++; if (pulses_since(s0) !== 0) begin errors++; $display("FAIL midreset_early_pulses got %0d exp 0", pulses_since(s0)); end
    run_scan(16'h1 << 3, 1'b0);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL midreset_accept got %b exp 1", key_valid); end
    checks++; if (value !== 16'h0003) begin errors++; $display("FAIL midreset_value_after got %h exp 0003", value); end
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL midreset_count_after got %0d exp 1", digit_count); end
    repeat (6) run_scan(16'h0, 1'b0);
    checks++; if (stray !== 0) begin errors++; $display("FAIL midreset_stray got %0d exp 0", stray); end
  endtask

  task automatic test_random();
    int s0 = scan_idx;
    logic [15:0] mask = 16'h0;
    int sel;
    bit clr;
    stray = 0;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 6 && sel <= 7) mask = 16'h0;
      else if (sel == 8)        mask = 16'h1 << $urandom_range(0, 15);
      else if (sel == 9)        mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      clr = ($urandom_range(0, 24) == 0);
      run_scan(mask, clr);
    end
    repeat (6) run_scan(16'h0, 1'b0);
    for (int s = s0 + 1; s <= scan_idx && s < 1024; s++) begin
      checks++;
      if (obs_kv[s] !== exp_kv[s]) begin errors++; $display("FAIL rand_pulse scan %0d got %b exp %b", s, obs_kv[s], exp_kv[s]); end
    end
    checks++; if (value !== m_value) begin errors++; $display("FAIL rand_value got %h exp %h", value, m_value); end
    checks++; if (key_code !== m_code) begin errors++; $display("FAIL rand_code got %h exp %h", key_code, m_code); end
    checks++; if (digit_count !== 3'(m_count)) begin errors++; $display("FAIL rand_count got %0d exp %0d", digit_count, m_count); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rand_stray got %0d exp 0", stray); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_multi();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
